node_feeder: RTL and testbench

- Initiator side of the MAC node operand interface: accepts (a, b) operand pairs on a valid/ready stream and drives ain/bin/csel into one node so that each group of cfg_len pairs forms one dot product.
- Generates restart/accumulate (csel) sequencing and bubbles with zeros.
- Tracks node pipeline latency and strobes dot_done in the cycle the node's res holds a completed dot product, plus job_done after the last dot of a job.
- Sits between the matrix-vector controller/operand buffers and the node array.

---
 rtl/node_feeder_if.sv | 29 ++
 rtl/node_feeder.sv | 123 ++++++++++++
 tb/tb_node_feeder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/node_feeder_if.sv
// Operand stream and node-input bundle for node_feeder.
// NODE_FEEDER_SUB_EN adds the s_sub / subtract pair.
interface node_feeder_if #(
  parameter int AW = 25,
  parameter int BW = 18
);
  logic          s_valid;
  logic          s_ready;
  logic [AW-1:0] s_a;
  logic [BW-1:0] s_b;
  logic [AW-1:0] ain;
  logic [BW-1:0] bin;
  logic          csel;
`ifdef NODE_FEEDER_SUB_EN
  logic          s_sub;
  logic          subtract;

  // slave = the feeder itself, master = operand source / node observer
  modport slave  (input  s_valid, s_a, s_b, s_sub,
                  output s_ready, ain, bin, csel, subtract);
  modport master (output s_valid, s_a, s_b, s_sub,
                  input  s_ready, ain, bin, csel, subtract);
`else
  modport slave  (input  s_valid, s_a, s_b,
                  output s_ready, ain, bin, csel);
  modport master (output s_valid, s_a, s_b,
                  input  s_ready, ain, bin, csel);
`endif
endinterface

// File: rtl/node_feeder.sv
// Drives one MAC node with (a,b) pairs grouped into cfg_len-element dot products.
// Optional feature macro: NODE_FEEDER_SUB_EN (per-element subtract flag).
module node_feeder #(
  parameter int AW       = 25,
  parameter int BW       = 18,
  parameter int LEN_W    = 8,
  parameter int DOTS_W   = 8,
  parameter int NODE_LAT = 3
) (
  input  logic              clk,
  input  logic              sclr,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [DOTS_W-1:0] cfg_dots,
  node_feeder_if.slave      io,
  output logic              dot_done,
  output logic              job_done,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, idx_q, idx_d;
  logic [DOTS_W-1:0]   ndots_q, dots_q, dots_d;
  logic [AW-1:0]       ain_q, ain_d;
  logic [BW-1:0]       bin_q, bin_d;
  logic                csel_q, csel_d;
  // bit k set = the matching element reached the node input k cycles ago
  logic [NODE_LAT:0]   last_pipe_q, fin_pipe_q;

  logic accept, elem_last, dot_final, last_in, fin_in, load;

  assign load      = (state_q == IDLE) && start;
  assign accept    = (state_q == RUN) && io.s_valid;
  assign elem_last = (idx_q == len_q - LEN_W'(1));
  assign dot_final = (dots_q == ndots_q - DOTS_W'(1));
  assign last_in   = accept && elem_last;
  assign fin_in    = last_in && dot_final;

  // state register
  always_ff @(posedge clk) begin
    if (sclr) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (fin_in) state_d = DRAIN;
      DRAIN:   if (fin_pipe_q[NODE_LAT]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs and datapath next values
  always_comb begin
    io.s_ready = (state_q == RUN);
    busy       = (state_q != IDLE);
    ain_d      = accept ? io.s_a : '0;
    bin_d      = accept ? io.s_b : '0;
    csel_d     = accept ? (idx_q != '0) : 1'b1;
    idx_d      = idx_q;
    dots_d     = dots_q;
    if (load) begin
      idx_d  = '0;
      dots_d = '0;
    end else if (accept) begin
      if (elem_last) begin
        idx_d  = '0;
        dots_d = dots_q + DOTS_W'(1);
      end else begin
        idx_d  = idx_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      len_q       <= LEN_W'(1);
      ndots_q     <= DOTS_W'(1);
      idx_q       <= '0;
      dots_q      <= '0;
      ain_q       <= '0;
      bin_q       <= '0;
      csel_q      <= 1'b1;
      last_pipe_q <= '0;
      fin_pipe_q  <= '0;
    end else begin
      if (load) begin
        len_q   <= (cfg_len  == '0) ? LEN_W'(1)  : cfg_len;
        ndots_q <= (cfg_dots == '0) ? DOTS_W'(1) : cfg_dots;
      end
      idx_q       <= idx_d;
      dots_q      <= dots_d;
      ain_q       <= ain_d;
      bin_q       <= bin_d;
      csel_q      <= csel_d;
      last_pipe_q <= {last_pipe_q[NODE_LAT-1:0], last_in};
      fin_pipe_q  <= {fin_pipe_q[NODE_LAT-1:0], fin_in};
    end
  end

  assign io.ain   = ain_q;
  assign io.bin   = bin_q;
  assign io.csel  = csel_q;
  assign dot_done = last_pipe_q[NODE_LAT];
  assign job_done = fin_pipe_q[NODE_LAT];

`ifdef NODE_FEEDER_SUB_EN
  logic sub_q;

  always_ff @(posedge clk) begin
    if (sclr) sub_q <= 1'b0;
    else      sub_q <= accept && io.s_sub;
  end

  assign io.subtract = sub_q;
`endif

endmodule

// File: tb/tb_node_feeder.sv
// Randomized self-checking bench for node_feeder against a time-indexed expectation model.
module tb_node_feeder;
  localparam int AW = 25, BW = 18, LEN_W = 8, DOTS_W = 8, LAT = 3;
  localparam int RING = 64;

  logic              clk = 1'b0;
  logic              sclr, start;
  logic [LEN_W-1:0]  cfg_len;
  logic [DOTS_W-1:0] cfg_dots;
  logic              dot_done, job_done, busy;

  node_feeder_if #(.AW(AW), .BW(BW)) nif ();

  node_feeder #(.AW(AW), .BW(BW), .LEN_W(LEN_W), .DOTS_W(DOTS_W), .NODE_LAT(LAT)) dut (
    .clk(clk), .sclr(sclr), .start(start), .cfg_len(cfg_len), .cfg_dots(cfg_dots),
    .io(nif.slave), .dot_done(dot_done), .job_done(job_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, cyc = 0;

  // expected node-side values, indexed by cycle modulo RING
  logic [AW-1:0] e_ain [RING];
  logic [BW-1:0] e_bin [RING];
  logic          e_csel[RING];
  logic          e_dd  [RING];
  logic          e_jd  [RING];
  logic          e_sub [RING];

  // job-level model: running flag, last busy cycle once draining, element count
  bit m_run = 1'b0;
  int m_busy_end = -1;
  int m_len = 1, m_dots = 1, m_n = 0;

  logic [AW-1:0] da[4];
  logic [BW-1:0] db[4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clr(input int k);
    e_ain[k] = '0; e_bin[k] = '0; e_csel[k] = 1'b1;
    e_dd[k] = 1'b0; e_jd[k] = 1'b0; e_sub[k] = 1'b0;
  endtask

  function automatic bit m_busy();
    return m_run || (cyc <= m_busy_end);
  endfunction

  // check the current cycle, advance the model with the driven inputs, then clock
  task automatic tick();
    int k, t, pos;
    @(negedge clk);
    k = cyc % RING;
    chk("ain",      64'(nif.ain),     64'(e_ain[k]));
    chk("bin",      64'(nif.bin),     64'(e_bin[k]));
    chk("csel",     64'(nif.csel),    64'(e_csel[k]));
    chk("dot_done", 64'(dot_done),    64'(e_dd[k]));
    chk("job_done", 64'(job_done),    64'(e_jd[k]));
    chk("s_ready",  64'(nif.s_ready), 64'(m_run));
    chk("busy",     64'(busy),        64'(m_busy()));
`ifdef NODE_FEEDER_SUB_EN
    chk("subtract", 64'(nif.subtract), 64'(e_sub[k]));
`endif
    clr(k);
    if (sclr) begin
      for (int j = 1; j <= LAT + 2; j++) clr((cyc + j) % RING);
      m_run = 1'b0; m_busy_end = -1; m_n = 0;
    end else if (m_run && nif.s_valid) begin
      t   = (cyc + 1) % RING;
      pos = m_n % m_len;
      e_ain[t]  = nif.s_a;
      e_bin[t]  = nif.s_b;
      e_csel[t] = (pos != 0);
`ifdef NODE_FEEDER_SUB_EN
      e_sub[t]  = nif.s_sub;
`endif
      if (pos == m_len - 1) e_dd[(cyc + 1 + LAT) % RING] = 1'b1;
      if (m_n == m_len * m_dots - 1) begin
        e_jd[(cyc + 1 + LAT) % RING] = 1'b1;
        m_run = 1'b0;
        m_busy_end = cyc + 1 + LAT;
      end
      m_n++;
    end else if (!m_busy() && start) begin
      m_run  = 1'b1;
      m_len  = (cfg_len == 0) ? 1 : int'(cfg_len);
      m_dots = (cfg_dots == 0) ? 1 : int'(cfg_dots);
      m_n    = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // one job: gaps of gmin..gmax idle cycles between elements, optional abort before element abort_at
  task automatic run_job(input int len, input int dots, input int gmin, input int gmax,
                         input int abort_at, input bit dir);
    int ne, gaps, w;
    start = 1'b1; cfg_len = LEN_W'(len); cfg_dots = DOTS_W'(dots); nif.s_valid = 1'b0;
    tick();
    start = 1'b0;
    ne = ((len == 0) ? 1 : len) * ((dots == 0) ? 1 : dots);
    for (int i = 0; i < ne; i++) begin
      if (i == abort_at) begin
        nif.s_valid = 1'b1; sclr = 1'b1;
        tick();
        sclr = 1'b0; nif.s_valid = 1'b0;
        repeat (2 * LAT) tick();
        return;
      end
      gaps = (i > 0) ? int'($urandom_range(gmax, gmin)) : 0;
      repeat (gaps) begin
        nif.s_valid = 1'b0; nif.s_a = AW'($urandom); nif.s_b = BW'($urandom);
        start = ($urandom_range(0, 3) == 0);
        tick();
      end
      start = 1'b0;
      nif.s_valid = 1'b1;
      nif.s_a = (dir && i < 4) ? da[i] : AW'($urandom);
      nif.s_b = (dir && i < 4) ? db[i] : BW'($urandom);
`ifdef NODE_FEEDER_SUB_EN
      nif.s_sub = 1'($urandom);
`endif
      tick();
    end
    w = 0;
    while (m_busy() && w < 100) begin
      nif.s_valid = 1'($urandom); nif.s_a = AW'($urandom); nif.s_b = BW'($urandom);
      tick();
      w++;
    end
    nif.s_valid = 1'b0;
    if (m_busy()) chk("drain_timeout", 64'(1), 64'(0));
    tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < RING; k++) clr(k);
    sclr = 1'b1; start = 1'b0; cfg_len = '0; cfg_dots = '0;
    nif.s_valid = 1'b0; nif.s_a = '0; nif.s_b = '0;
`ifdef NODE_FEEDER_SUB_EN
    nif.s_sub = 1'b0;
`endif
    @(posedge clk); #1;
    repeat (5) tick();
    sclr = 1'b0;
    tick();

    da[0] = 25'h000AAAA; da[1] = 25'h000AAAA; da[2] = 25'h000AAAA; da[3] = '0;
    db[0] = 18'h04000;   db[1] = 18'h02020;   db[2] = 18'h02017;   db[3] = '0;
    run_job(3, 1, 0, 0, -1, 1'b1);

    da[0] = 25'h0008000; da[1] = 25'h0008000; da[2] = '0; da[3] = '0;
    db[0] = 18'h18000;   db[1] = 18'h14000;   db[2] = '0; db[3] = '0;
    run_job(2, 2, 0, 0, -1, 1'b1);

    run_job(2, 1, 2, 2, -1, 1'b0);
    run_job(0, 0, 0, 0, -1, 1'b0);
    run_job(3, 1, 0, 0, 1, 1'b0);
    run_job(3, 1, 0, 1, -1, 1'b0);
    run_job(1, 3, 0, 0, -1, 1'b0);
    run_job(255, 2, 0, 0, -1, 1'b0);

    for (int j = 0; j < 40; j++) begin
      int ln, dt, ab;
      ln = $urandom_range(0, 5);
      dt = $urandom_range(0, 3);
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1;
      run_job(ln, dt, 0, $urandom_range(0, 2), ab, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
